mc8051_mem_arb: RTL and testbench

External memory arbiter/sequencer between `mc8051_top`'s memory bus and a single synchronous 8-bit RAM, shared with a second requester (DMA / debug loader). It converts the core's `psen_n`/`rd_n`/`we_n` strobes into a fixed-wait-state RAM access. It generates the core's `mem_data_rdy` handshake and round-robins RAM access with the DMA port. Code and xdata spaces share one RAM and are separated by address bit 16.

---
 rtl/mc8051_mem_pkg.sv | 17 +
 rtl/mc8051_mem_arb_if.sv | 45 ++++
 rtl/mc8051_mem_arb.sv | 150 +++++++++++++++
 tb/tb_mc8051_mem_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc8051_mem_pkg.sv
// Shared definitions for the mc8051 external memory arbiter: FSM state
// encoding, RAM address width and the code/xdata space-select values.
package mc8051_mem_pkg;

  // 17-bit RAM address: bit 16 splits code space from xdata space.
  localparam int RAM_AW = 17;

  localparam logic SPACE_CODE  = 1'b0;
  localparam logic SPACE_XDATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mc8051_mem_arb_if.sv
// Requester-side bus of the memory arbiter: the 8051 core strobes and the
// DMA/debug-loader request port.
//
// Handshakes:
//   CPU: a request is any of cpu_psen_n/cpu_rd_n/cpu_we_n low. The arbiter
//   drops cpu_data_rdy while the access runs and raises it on completion;
//   the core holds strobe, address and write data until it sees
//   cpu_data_rdy=1 again, and cpu_rdata is valid from that point.
//   DMA: dma_req is a level held until dma_gnt pulses for one cycle (address,
//   direction and write data are captured then). dma_done pulses one cycle
//   when the access is finished; dma_rdata is valid with it and held until
//   the next DMA completion.
interface mc8051_mem_arb_if;
  import mc8051_mem_pkg::*;

  logic              cpu_psen_n;
  logic              cpu_rd_n;
  logic              cpu_we_n;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_data_rdy;
  logic              dma_req;
  logic              dma_we;
  logic [RAM_AW-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [7:0]        dma_rdata;

  // Requester side (core model / DMA engine).
  modport master (
    output cpu_psen_n, cpu_rd_n, cpu_we_n, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  cpu_rdata, cpu_data_rdy, dma_gnt, dma_done, dma_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_psen_n, cpu_rd_n, cpu_we_n, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output cpu_rdata, cpu_data_rdy, dma_gnt, dma_done, dma_rdata
  );

endinterface

// File: rtl/mc8051_mem_arb.sv
// External memory arbiter/sequencer: shares one synchronous 8-bit RAM between
// the 8051 core and a DMA port. Each access holds ram_en for WAIT_CYC+1
// cycles and is followed by one IDLE cycle; ties alternate via last_dma.
module mc8051_mem_arb
  import mc8051_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  mc8051_mem_arb_if.slave   bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output arb_state_e        dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_data_rdy_q, cpu_data_rdy_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              dma_done_q, dma_done_d;
  logic [7:0]        dma_rdata_q, dma_rdata_d;

  // Strobe decode: psen beats rd beats we when several are low together.
  logic cpu_req;
  logic cpu_is_we;
  logic cpu_space;
  logic grant_cpu;
  logic grant_dma;

  assign cpu_req   = ~bus.cpu_psen_n | ~bus.cpu_rd_n | ~bus.cpu_we_n;
  assign cpu_is_we = bus.cpu_psen_n & bus.cpu_rd_n & ~bus.cpu_we_n;
  assign cpu_space = ~bus.cpu_psen_n ? SPACE_CODE : SPACE_XDATA;
  // On a tie the requester that was not served last wins.
  assign grant_cpu = cpu_req & (~bus.dma_req | last_dma_q);
  assign grant_dma = bus.dma_req & (~cpu_req | ~last_dma_q);

  // Next-state and output computation for the arbitration/access FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_dma_d     = last_dma_q;
    ram_en_d       = ram_en_q;
    ram_we_d       = ram_we_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_data_rdy_d = cpu_data_rdy_q;
    dma_gnt_d      = 1'b0;
    dma_done_d     = 1'b0;
    dma_rdata_d    = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d        = CPU_ACC;
          cnt_d          = WAIT_INIT;
          last_dma_d     = 1'b0;
          ram_en_d       = 1'b1;
          ram_we_d       = cpu_is_we;
          ram_addr_d     = {cpu_space, bus.cpu_addr};
          ram_wdata_d    = bus.cpu_wdata;
          cpu_data_rdy_d = 1'b0;
        end else if (grant_dma) begin
          state_d     = DMA_ACC;
          cnt_d       = WAIT_INIT;
          last_dma_d  = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.dma_we;
          ram_addr_d  = bus.dma_addr;
          ram_wdata_d = bus.dma_wdata;
          dma_gnt_d   = 1'b1;
        end
      end
      CPU_ACC, DMA_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          if (state_q == CPU_ACC) begin
            cpu_data_rdy_d = 1'b1;
            if (!ram_we_q) cpu_rdata_d = ram_rdata;
          end else begin
            dma_done_d = 1'b1;
            if (!ram_we_q) dma_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      last_dma_q     <= 1'b1;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= 8'h00;
      cpu_rdata_q    <= 8'h00;
      cpu_data_rdy_q <= 1'b1;
      dma_gnt_q      <= 1'b0;
      dma_done_q     <= 1'b0;
      dma_rdata_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_dma_q     <= last_dma_d;
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_data_rdy_q <= cpu_data_rdy_d;
      dma_gnt_q      <= dma_gnt_d;
      dma_done_q     <= dma_done_d;
      dma_rdata_q    <= dma_rdata_d;
    end
  end

  assign ram_en           = ram_en_q;
  assign ram_we           = ram_we_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_data_rdy = cpu_data_rdy_q;
  assign bus.dma_gnt      = dma_gnt_q;
  assign bus.dma_done     = dma_done_q;
  assign bus.dma_rdata    = dma_rdata_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mc8051_mem_arb.sv
// Bench for mc8051_mem_arb: one instance with WAIT_CYC=2 and one with
// WAIT_CYC=0 share a behavioural RAM (asynchronous read, clocked write).
module tb_mc8051_mem_arb;
  import mc8051_mem_pkg::*;

  localparam int WAIT_A = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  mc8051_mem_arb_if bus_a ();
  mc8051_mem_arb_if bus_b ();
  logic ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [16:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  arb_state_e state_a, state_b;

  mc8051_mem_arb #(.WAIT_CYC(WAIT_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a), .dbg_state(state_a));

  mc8051_mem_arb #(.WAIT_CYC(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b), .dbg_state(state_b));

  // ---------------- RAM model ----------------
  logic [7:0] mem [0:131071];
  logic pre_en = 1'b0;
  logic [16:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    else if (ram_en_b && ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
  end
  assign ram_rdata_a = mem[ram_addr_a];
  assign ram_rdata_b = mem[ram_addr_b];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic own_q[$];
  int dma_done_seen = 0;
  always @(negedge clk) if (bus_a.dma_done) dma_done_seen <= dma_done_seen + 1;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus_a.cpu_psen_n = 1'b1; bus_a.cpu_rd_n = 1'b1; bus_a.cpu_we_n = 1'b1;
    bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_a.dma_req = 1'b0; bus_a.dma_we = 1'b0; bus_a.dma_addr = '0; bus_a.dma_wdata = '0;
    bus_b.cpu_psen_n = 1'b1; bus_b.cpu_rd_n = 1'b1; bus_b.cpu_we_n = 1'b1;
    bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.dma_req = 1'b0; bus_b.dma_we = 1'b0; bus_b.dma_addr = '0; bus_b.dma_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // kind: 0 psen, 1 rd, 2 we, 3 psen+rd together
  task automatic cpu_access(input int kind, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rdata, input logic [16:0] exp_addr,
                            input string name);
    int t, low, en_cnt;
    logic [16:0] s_addr;
    logic s_we;
    logic [7:0] s_wdata, e;
    logic exp_we;
    exp_we = (kind == 2);
    @(negedge clk);
    bus_a.cpu_addr = addr; bus_a.cpu_wdata = wdata;
    if (kind == 0 || kind == 3) bus_a.cpu_psen_n = 1'b0;
    if (kind == 1 || kind == 3) bus_a.cpu_rd_n = 1'b0;
    if (kind == 2) bus_a.cpu_we_n = 1'b0;
    if (!exp_we) exp_q.push_back(exp_rdata);
    t = 0;
    @(negedge clk);
    while (bus_a.cpu_data_rdy && t < 20) begin @(negedge clk); t++; end
    total++;
    if (bus_a.cpu_data_rdy) begin
      bad++;
      $display("FAIL %s_start: cpu_data_rdy stayed %0b, required 0 within 20 cycles", name, bus_a.cpu_data_rdy);
      idle_inputs();
      if (!exp_we) void'(exp_q.pop_back());
      return;
    end
    s_addr = ram_addr_a; s_we = ram_we_a; s_wdata = ram_wdata_a;
    low = 0; en_cnt = 0;
    while (!bus_a.cpu_data_rdy && low < 40) begin
      low++;
      if (ram_en_a) en_cnt++;
      @(negedge clk);
    end
    bus_a.cpu_psen_n = 1'b1; bus_a.cpu_rd_n = 1'b1; bus_a.cpu_we_n = 1'b1;
    total++;
    if (s_addr !== exp_addr) begin bad++; $display("FAIL %s_addr: ram_addr=%05h required %05h", name, s_addr, exp_addr); end
    total++;
    if (s_we !== exp_we) begin bad++; $display("FAIL %s_we: ram_we=%0b required %0b", name, s_we, exp_we); end
    if (exp_we) begin
      total++;
      if (s_wdata !== wdata) begin bad++; $display("FAIL %s_wdata: ram_wdata=%02h required %02h", name, s_wdata, wdata); end
    end
    total++;
    if (low != WAIT_A + 1) begin bad++; $display("FAIL %s_rdy_low: low for %0d cycles, required %0d", name, low, WAIT_A + 1); end
    total++;
    if (en_cnt != WAIT_A + 1) begin bad++; $display("FAIL %s_en_len: ram_en high %0d cycles, required %0d", name, en_cnt, WAIT_A + 1); end
    total++;
    if (ram_en_a !== 1'b0) begin bad++; $display("FAIL %s_en_off: ram_en=%0b required 0", name, ram_en_a); end
    if (!exp_we) begin
      e = exp_q.pop_front();
      total++;
      if (bus_a.cpu_rdata !== e) begin bad++; $display("FAIL %s_rdata: cpu_rdata=%02h required %02h", name, bus_a.cpu_rdata, e); end
    end
  endtask

  task automatic dma_access(input logic we, input logic [16:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rdata, input string name);
    int t, lat;
    logic [7:0] e;
    @(negedge clk);
    bus_a.dma_req = 1'b1; bus_a.dma_we = we; bus_a.dma_addr = addr; bus_a.dma_wdata = wdata;
    if (!we) exp_q.push_back(exp_rdata);
    t = 0;
    @(negedge clk);
    while (!bus_a.dma_gnt && t < 20) begin @(negedge clk); t++; end
    bus_a.dma_req = 1'b0;
    total++;
    if (!bus_a.dma_gnt) begin
      bad++;
      $display("FAIL %s_gnt: dma_gnt=%0b required 1 within 20 cycles", name, bus_a.dma_gnt);
      if (!we) void'(exp_q.pop_back());
      return;
    end
    total++;
    if (ram_addr_a !== addr || ram_we_a !== we || ram_en_a !== 1'b1) begin
      bad++;
      $display("FAIL %s_ram: en/we/addr=%0b/%0b/%05h required 1/%0b/%05h", name, ram_en_a, ram_we_a, ram_addr_a, we, addr);
    end
    @(negedge clk);
    lat = 1;
    total++;
    if (bus_a.dma_gnt !== 1'b0) begin bad++; $display("FAIL %s_gnt_pulse: dma_gnt=%0b required 0 one cycle later", name, bus_a.dma_gnt); end
    while (!bus_a.dma_done && lat < 40) begin @(negedge clk); lat++; end
    total++;
    if (lat != WAIT_A + 1) begin bad++; $display("FAIL %s_done_lat: done after %0d cycles, required %0d", name, lat, WAIT_A + 1); end
    if (!we) begin
      e = exp_q.pop_front();
      total++;
      if (bus_a.dma_rdata !== e) begin bad++; $display("FAIL %s_rdata: dma_rdata=%02h required %02h", name, bus_a.dma_rdata, e); end
      @(negedge clk);
      total++;
      if (bus_a.dma_done !== 1'b0 || bus_a.dma_rdata !== e) begin
        bad++;
        $display("FAIL %s_hold: done/rdata=%0b/%02h required 0/%02h", name, bus_a.dma_done, bus_a.dma_rdata, e);
      end
    end
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (bus_a.cpu_data_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: cpu_data_rdy=%0b required 1", bus_a.cpu_data_rdy); end
    total++;
    if ({ram_en_a, ram_we_a, bus_a.dma_gnt, bus_a.dma_done} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: en/we/gnt/done=%04b required 0000", {ram_en_a, ram_we_a, bus_a.dma_gnt, bus_a.dma_done});
    end
    total++;
    if (ram_addr_a !== 17'h0 || ram_wdata_a !== 8'h0) begin
      bad++; $display("FAIL reset_ram_bus: addr/wdata=%05h/%02h required 00000/00", ram_addr_a, ram_wdata_a);
    end
    total++;
    if (bus_a.cpu_rdata !== 8'h0 || bus_a.dma_rdata !== 8'h0) begin
      bad++; $display("FAIL reset_rdata: cpu/dma=%02h/%02h required 00/00", bus_a.cpu_rdata, bus_a.dma_rdata);
    end
    total++;
    if (state_a !== IDLE) begin bad++; $display("FAIL reset_state: state=%0d required %0d", state_a, IDLE); end
  endtask

  task automatic test_fetch();
    preload(17'h00003, 8'h74);
    cpu_access(0, 16'h0003, 8'h00, 8'h74, 17'h00003, "fetch");
  endtask

  task automatic test_xdata_write();
    preload(17'h100F0, 8'h00);
    cpu_access(2, 16'h00F0, 8'h12, 8'h00, 17'h100F0, "xwrite");
    cpu_access(1, 16'h00F0, 8'h00, 8'h12, 17'h100F0, "xread");
  endtask

  task automatic test_multi_strobe();
    preload(17'h00010, 8'hA5);
    preload(17'h10010, 8'h3C);
    cpu_access(3, 16'h0010, 8'h00, 8'hA5, 17'h00010, "multi");
  endtask

  task automatic test_dma();
    dma_access(1'b1, 17'h00100, 8'h5B, 8'h00, "dma_wr");
    dma_access(1'b0, 17'h00100, 8'h00, 8'h5B, "dma_rd");
    dma_access(1'b0, 17'h100F0, 8'h00, 8'h12, "dma_rd_x");
  endtask

  task automatic test_tie();
    int t, n, cpu_n, dma_n;
    logic prev_en, got, e;
    apply_reset();
    preload(17'h00020, 8'h11);
    preload(17'h10020, 8'h22);
    for (int i = 0; i < 20; i++) own_q.push_back(i[0]);
    @(negedge clk);
    bus_a.cpu_addr = 16'h0020; bus_a.cpu_psen_n = 1'b0;
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 17'h10020;
    prev_en = ram_en_a;
    t = 0; n = 0; cpu_n = 0; dma_n = 0;
    while (n < 20 && t < 400) begin
      @(negedge clk);
      t++;
      if (ram_en_a && !prev_en) begin
        got = bus_a.dma_gnt;
        e = own_q.pop_front();
        n++;
        if (got) dma_n++; else cpu_n++;
        total++;
        if (got !== e) begin bad++; $display("FAIL tie_order_%0d: owner dma=%0b required dma=%0b", n, got, e); end
        if (n == 20) begin bus_a.cpu_psen_n = 1'b1; bus_a.dma_req = 1'b0; end
      end
      prev_en = ram_en_a;
    end
    bus_a.cpu_psen_n = 1'b1; bus_a.dma_req = 1'b0;
    total++;
    if (n != 20) begin bad++; $display("FAIL tie_count: %0d accesses seen, required 20", n); end
    own_q.delete();
    repeat (WAIT_A + 3) @(negedge clk);
    total++;
    if (cpu_n - dma_n > 1 || dma_n - cpu_n > 1) begin
      bad++; $display("FAIL tie_balance: cpu=%0d dma=%0d required within 1", cpu_n, dma_n);
    end
    total++;
    if (bus_a.cpu_rdata !== 8'h11 || bus_a.dma_rdata !== 8'h22) begin
      bad++; $display("FAIL tie_rdata: cpu/dma=%02h/%02h required 11/22", bus_a.cpu_rdata, bus_a.dma_rdata);
    end
    total++;
    if (ram_en_a !== 1'b0 || bus_a.cpu_data_rdy !== 1'b1) begin
      bad++; $display("FAIL tie_idle: en/rdy=%0b/%0b required 0/1", ram_en_a, bus_a.cpu_data_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int t, low, gcyc, prev_g;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) preload(17'(i), 8'hC0 + 8'(i));
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    bus_b.cpu_addr = 16'h0000; bus_b.cpu_psen_n = 1'b0;
    prev_g = 0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      @(negedge clk);
      while (bus_b.cpu_data_rdy && t < 10) begin @(negedge clk); t++; end
      gcyc = cyc;
      total++;
      if (bus_b.cpu_data_rdy || ram_addr_b !== 17'(i)) begin
        bad++; $display("FAIL b2b_grant_%0d: rdy/addr=%0b/%05h required 0/%05h", i, bus_b.cpu_data_rdy, ram_addr_b, 17'(i));
      end
      if (i > 0) begin
        total++;
        if (gcyc - prev_g != 2) begin bad++; $display("FAIL b2b_period_%0d: %0d cycles, required 2", i, gcyc - prev_g); end
      end
      low = 0;
      while (!bus_b.cpu_data_rdy && low < 10) begin low++; @(negedge clk); end
      total++;
      if (low != 1) begin bad++; $display("FAIL b2b_low_%0d: rdy low %0d cycles, required 1", i, low); end
      e = exp_q.pop_front();
      total++;
      if (bus_b.cpu_rdata !== e) begin bad++; $display("FAIL b2b_rdata_%0d: cpu_rdata=%02h required %02h", i, bus_b.cpu_rdata, e); end
      if (i < 3) bus_b.cpu_addr = 16'(i + 1);
      else bus_b.cpu_psen_n = 1'b1;
      prev_g = gcyc;
    end
  endtask

  task automatic test_reset_mid_access();
    int t, done0;
    @(negedge clk);
    done0 = dma_done_seen;
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 17'h10020;
    t = 0;
    @(negedge clk);
    while (!bus_a.dma_gnt && t < 20) begin @(negedge clk); t++; end
    bus_a.dma_req = 1'b0;
    total++;
    if (!bus_a.dma_gnt) begin bad++; $display("FAIL rmid_gnt: dma_gnt=%0b required 1", bus_a.dma_gnt); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (ram_en_a !== 1'b0 || bus_a.cpu_data_rdy !== 1'b1) begin
      bad++; $display("FAIL rmid_immediate: en/rdy=%0b/%0b required 0/1", ram_en_a, bus_a.cpu_data_rdy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (dma_done_seen != done0) begin bad++; $display("FAIL rmid_done: %0d done pulses, required 0", dma_done_seen - done0); end
    total++;
    if (bus_a.dma_rdata !== 8'h00 || ram_en_a !== 1'b0) begin
      bad++; $display("FAIL rmid_rdata: dma_rdata/en=%02h/%0b required 00/0", bus_a.dma_rdata, ram_en_a);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_xdata_write();
    test_multi_strobe();
    test_dma();
    test_tie();
    test_back_to_back();
    test_reset_mid_access();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
